// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand input path: state encoding,
// operand width, default clear value and fetch-length saturation.
package alu_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  localparam int unsigned OPERAND_W = 8;
  localparam logic [OPERAND_W-1:0] DEFAULT_CLEAR_VALUE = 8'h00;

  // Requests longer than the configured maximum are clipped, never rejected.
  function automatic logic [1:0] sat_len(input logic [1:0] len, input logic [1:0] max_len);
    logic [1:0] res;
    if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/operand_shift_pair.sv
// Two-deep operand shift register (OP, OPold) with load-enable, synchronous
// clear and complemented outputs for the ALU operand multiplexer.
module operand_shift_pair
  import alu_pkg::*;
#(
  parameter logic [OPERAND_W-1:0] CLEAR_VALUE = DEFAULT_CLEAR_VALUE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [OPERAND_W-1:0] data_i,
  output logic [OPERAND_W-1:0] not_op_o,
  output logic [OPERAND_W-1:0] not_op_old_o
);

  logic [OPERAND_W-1:0] op_q;
  logic [OPERAND_W-1:0] op_old_q;

  // Shift the new byte in on load; clear dominates load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= CLEAR_VALUE;
      op_old_q <= CLEAR_VALUE;
    end else if (clr_i) begin
      op_q     <= CLEAR_VALUE;
      op_old_q <= CLEAR_VALUE;
    end else if (load_i) begin
      op_old_q <= op_q;
      op_q     <= data_i;
    end else begin
      op_q     <= op_q;
      op_old_q <= op_old_q;
    end
  end

  assign not_op_o     = ~op_q;
  assign not_op_old_o = ~op_old_q;

endmodule

// File: rtl/operand_fetch_latch.sv
// Operand fetch stage: pulls 0..MAX_BYTES bytes over a valid/ready bus,
// keeps the last two bytes and pulses fetch_done when a fetch completes.
module operand_fetch_latch
  import alu_pkg::*;
#(
  parameter int unsigned          MAX_BYTES   = 2,
  parameter logic [OPERAND_W-1:0] CLEAR_VALUE = DEFAULT_CLEAR_VALUE
) (
  input  logic                 CLK,
  input  logic                 notRESET,
  input  logic                 fetch_req,
  input  logic [1:0]           fetch_len,
  input  logic [OPERAND_W-1:0] bus_data,
  input  logic                 bus_valid,
  output logic                 bus_ready,
  input  logic                 clear,
  output logic [OPERAND_W-1:0] notOP,
  output logic [OPERAND_W-1:0] notOPold,
  output logic [1:0]           op_count,
  output logic                 fetch_done,
  output logic                 busy
);

  localparam logic [1:0] MAX_LEN = 2'(MAX_BYTES);

  fetch_state_e state_q, state_d;
  logic [1:0]   remaining_q, remaining_d;
  logic [1:0]   op_count_q, op_count_d;
  logic         done_q, done_d;
  logic [1:0]   len_s;
  logic         accept_s;

  assign len_s    = sat_len(fetch_len, MAX_LEN);
  assign accept_s = (state_q == ST_FETCH) && bus_valid && !clear;

  // Next-state, byte counter and completion decode.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    op_count_d  = op_count_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          op_count_d = 2'd0;
        end else if (fetch_req) begin
          op_count_d = 2'd0;
          if (len_s == 2'd0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_FETCH;
            remaining_d = len_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (clear) begin
          state_d     = ST_IDLE;
          remaining_d = 2'd0;
          op_count_d  = 2'd0;
        end else if (bus_valid) begin
          op_count_d  = op_count_q + 2'd1;
          remaining_d = remaining_q - 2'd1;
          if (remaining_q == 2'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = 2'd0;
        op_count_d  = 2'd0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      state_q     <= ST_IDLE;
      remaining_q <= 2'd0;
      op_count_q  <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      op_count_q  <= op_count_d;
      done_q      <= done_d;
    end
  end

  operand_shift_pair #(
    .CLEAR_VALUE(CLEAR_VALUE)
  ) u_shift_pair (
    .clk_i       (CLK),
    .rst_ni      (notRESET),
    .clr_i       (clear),
    .load_i      (accept_s),
    .data_i      (bus_data),
    .not_op_o    (notOP),
    .not_op_old_o(notOPold)
  );

  assign bus_ready  = (state_q == ST_FETCH);
  assign busy       = (state_q == ST_FETCH);
  assign op_count   = op_count_q;
  assign fetch_done = done_q;

endmodule
